// File: rtl/ddr4_odt_sched_pkg.sv
// Shared sizing, error-bit indices and bus payload types for the ODT scheduler.
package ddr4_odt_sched_pkg;

  localparam int unsigned RANKS    = 2;
  localparam int unsigned PHASES   = 8;
  localparam int unsigned SLOTS    = 4;
  localparam int unsigned MAX_SPAN = 32;
  localparam int unsigned DW       = 6;

  localparam int unsigned RW     = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int unsigned SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned STEP   = PHASES / SLOTS;
  // Window length: whole clocks covering MAX_SPAN plus one clock of slot offset headroom
  localparam int unsigned L      = PHASES * ((MAX_SPAN + PHASES - 1) / PHASES) + PHASES;
  localparam int unsigned SPAN_W = DW + 1;
  localparam int unsigned IDX_W  = DW + 2;

  localparam int unsigned ERR_RDWR = 0;
  localparam int unsigned ERR_CLIP = 1;
  localparam int unsigned ERR_CFG  = 2;
  localparam int unsigned ERR_W    = 3;

  typedef struct packed {
    logic [DW-1:0]          wr_del;
    logic [DW-1:0]          wr_dur;
    logic [DW-1:0]          rd_del;
    logic [DW-1:0]          rd_dur;
    logic [RANKS*RANKS-1:0] wr_map;
    logic [RANKS*RANKS-1:0] rd_map;
  } odt_cfg_t;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [SW-1:0] slot;
    logic [RW-1:0] rank;
  } cas_t;

endpackage

// File: rtl/ddr4_odt_sched_if.sv
// Controller-to-scheduler bus: config, CAS stream, disable and the per-phase ODT result.
interface ddr4_odt_sched_if;
  import ddr4_odt_sched_pkg::*;

  logic                     cfg_load;
  odt_cfg_t                 cfg;
  cas_t                     cas;
  logic                     odt_disable;
  logic [RANKS*PHASES-1:0]  mc_odt;
  logic                     odt_busy;
  logic [ERR_W-1:0]         err;

  modport master (output cfg_load, cfg, cas, odt_disable,
                  input  mc_odt, odt_busy, err);
  modport slave  (input  cfg_load, cfg, cas, odt_disable,
                  output mc_odt, odt_busy, err);
endinterface

// File: rtl/ddr4_odt_sched_window.sv
// One ODT pin's window register: shifts a clock's worth of phases out per clk and ORs in new windows.
module ddr4_odt_window
  import ddr4_odt_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              set_i,
  input  logic [IDX_W-1:0]  lo_i,
  input  logic [IDX_W-1:0]  hi_i,
  output logic [PHASES-1:0] odt_o,
  output logic              busy_o
);

  logic [L-1:0] w_q, w_d, mask;

  // Window mask covering phases [lo, hi) relative to the next output clock
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < L; i++) begin
      mask[i] = set_i && (IDX_W'(i) >= lo_i) && (IDX_W'(i) < hi_i);
    end
  end

  // Shift out the clock just presented, merge the new window, or flush on disable
  always_comb begin
    w_d = (w_q >> PHASES) | mask;
    if (clr_i) begin
      w_d = '0;
    end
  end

  // Window state; the low PHASES bits are what the PHY sees this clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign odt_o  = w_q[PHASES-1:0];
  assign busy_o = |w_q;

endmodule

// File: rtl/ddr4_odt_sched.sv
// Multi-rank ODT scheduler: turns the CAS stream into per-phase ODT pin windows for the PHY.
module ddr4_odt_sched
  import ddr4_odt_sched_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  ddr4_odt_sched_if.slave bus
);

  odt_cfg_t               cfg_q, cfg_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   cas_vld;
  logic [DW-1:0]          del, dur;
  logic [RANKS*RANKS-1:0] map;
  logic [RANKS-1:0]       pins;
  logic [SPAN_W-1:0]      span;
  logic                   clip;
  logic [IDX_W-1:0]       base, lo, hi;
  logic [RANKS-1:0]       rank_busy;
  logic                   busy_any;

  // CAS decode: writes win over reads, window bounds clipped at MAX_SPAN past the slot base
  always_comb begin
    cas_vld = !bus.odt_disable && (bus.cas.wr || bus.cas.rd);
    del     = bus.cas.wr ? cfg_q.wr_del : cfg_q.rd_del;
    dur     = bus.cas.wr ? cfg_q.wr_dur : cfg_q.rd_dur;
    map     = bus.cas.wr ? cfg_q.wr_map : cfg_q.rd_map;
    pins    = '0;
    for (int unsigned r = 0; r < RANKS; r++) begin
      if (bus.cas.rank == RW'(r)) begin
        pins = map[r*RANKS +: RANKS];
      end
    end
    span = SPAN_W'(del) + SPAN_W'(dur);
    clip = (dur != '0) && (span > SPAN_W'(MAX_SPAN));
    base = IDX_W'(bus.cas.slot) * IDX_W'(STEP);
    lo   = base + IDX_W'(del);
    hi   = base + (clip ? IDX_W'(MAX_SPAN) : IDX_W'(span));
  end

  // Config load gated on idle; sticky error collection
  always_comb begin
    cfg_d = cfg_q;
    err_d = err_q;
    if (bus.cfg_load) begin
      if (busy_any) begin
        err_d[ERR_CFG] = 1'b1;
      end else begin
        cfg_d = bus.cfg;
      end
    end
    if (cas_vld && bus.cas.wr && bus.cas.rd) begin
      err_d[ERR_RDWR] = 1'b1;
    end
    if (cas_vld && clip) begin
      err_d[ERR_CLIP] = 1'b1;
    end
  end

  // Active config and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
      err_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      err_q <= err_d;
    end
  end

  // One window per ODT pin, fed by the target rank's pin map
  for (genvar g = 0; g < RANKS; g++) begin : g_win
    ddr4_odt_window u_win (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (bus.odt_disable),
      .set_i  (cas_vld && pins[g]),
      .lo_i   (lo),
      .hi_i   (hi),
      .odt_o  (bus.mc_odt[g*PHASES +: PHASES]),
      .busy_o (rank_busy[g])
    );
  end

  assign busy_any     = |rank_busy;
  assign bus.odt_busy = busy_any;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ddr4_odt_sched.sv
// Self-checking bench: absolute-phase timeline model of ODT pins, directed scenarios then random traffic.
module tb_ddr4_odt_sched;
  import ddr4_odt_sched_pkg::*;

  localparam int unsigned NCYC = 2200;
  localparam int unsigned NPH  = NCYC * PHASES + L + PHASES;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ddr4_odt_sched_if bus();

  ddr4_odt_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ph[i][pin] = pin high at absolute phase i (clock i/PHASES, bit i%PHASES)
  bit [RANKS-1:0] ph [NPH];
  odt_cfg_t       cfg_m;
  logic [2:0]     err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (clk %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [RANKS*PHASES-1:0] exp_odt(input int m);
    logic [RANKS*PHASES-1:0] v = '0;
    for (int r = 0; r < RANKS; r++)
      for (int k = 0; k < PHASES; k++)
        if (m*PHASES + k < NPH) v[r*PHASES + k] = ph[m*PHASES + k][r];
    return v;
  endfunction

  function automatic logic exp_busy(input int m);
    for (int i = 0; i < L; i++)
      if (m*PHASES + i < NPH && ph[m*PHASES + i] != '0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_model();
    foreach (ph[i]) ph[i] = '0;
    err_m = '0;
    cfg_m = '0;
  endtask

  task automatic idle();
    bus.cfg_load    = 1'b0;
    bus.cas         = '0;
    bus.odt_disable = 1'b0;
  endtask

  // Advance one clock, apply the spec rules to the timeline, then check outputs
  task automatic tick();
    int n = cyc;
    logic busy_now = exp_busy(n);
    cas_t c = bus.cas;
    odt_cfg_t cf = bus.cfg;
    logic ld = bus.cfg_load;
    logic dis = bus.odt_disable;
    @(posedge clk);
    if (dis) begin
      for (int i = (n+1)*PHASES; i < (n+2)*PHASES + L && i < NPH; i++) ph[i] = '0;
    end else if (c.wr || c.rd) begin
      int del, dur, endp, b;
      logic [RANKS*RANKS-1:0] mp;
      logic [RANKS-1:0] pins;
      if (c.wr && c.rd) err_m[0] = 1'b1;
      del  = c.wr ? int'(cfg_m.wr_del) : int'(cfg_m.rd_del);
      dur  = c.wr ? int'(cfg_m.wr_dur) : int'(cfg_m.rd_dur);
      mp   = c.wr ? cfg_m.wr_map : cfg_m.rd_map;
      pins = mp[int'(c.rank)*RANKS +: RANKS];
      b    = int'(c.slot) * (PHASES / SLOTS);
      endp = del + dur;
      if (dur != 0 && endp > MAX_SPAN) begin
        err_m[1] = 1'b1;
        endp = MAX_SPAN;
      end
      for (int p = del; p < endp; p++)
        if ((n+1)*PHASES + b + p < NPH) ph[(n+1)*PHASES + b + p] |= pins;
    end
    if (ld) begin
      if (busy_now) err_m[2] = 1'b1;
      else cfg_m = cf;
    end
    cyc++;
    #1;
    chk("mc_odt", 32'(bus.mc_odt), 32'(exp_odt(cyc)));
    chk("busy", 32'(bus.odt_busy), 32'(exp_busy(cyc)));
    chk("err", 32'(bus.err), 32'(err_m));
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic load_cfg(input odt_cfg_t c);
    bus.cfg = c;
    bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
  endtask

  task automatic cas_pulse(input logic wr, input logic rd, input int slot, input int rank);
    bus.cas.wr   = wr;
    bus.cas.rd   = rd;
    bus.cas.slot = SW'(slot);
    bus.cas.rank = RW'(rank);
    tick();
    bus.cas = '0;
  endtask

  // Reset asserted in the middle of a clock: outputs must drop without waiting for an edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mc_odt", 32'(bus.mc_odt), 32'h0);
    chk("rst_busy", 32'(bus.odt_busy), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    clear_model();
    idle();
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    odt_cfg_t c;
    rst_n = 1'b0;
    bus.cfg = '0;
    idle();
    clear_model();
    @(posedge clk);
    #1;
    chk("reset_mc_odt", 32'(bus.mc_odt), 32'h0);
    chk("reset_busy", 32'(bus.odt_busy), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(2);

    // Write window: del 9, dur 6 on pin0 -> clk N+2 bits 1..6
    c = '0; c.wr_del = 6'd9; c.wr_dur = 6'd6; c.wr_map = 4'b0001;
    load_cfg(c);
    cas_pulse(1'b1, 1'b0, 0, 0);
    chk("t1_n1", 32'(bus.mc_odt), 32'h0000);
    tick();
    chk("t1_n2", 32'(bus.mc_odt), 32'h007E);
    ticks(3);

    // Back-to-back reads slot 2 rank 1 merge into one continuous window
    c.rd_del = 6'd10; c.rd_dur = 6'd8; c.rd_map = 4'b0100;
    load_cfg(c);
    cas_pulse(1'b0, 1'b1, 2, 1);
    cas_pulse(1'b0, 1'b1, 2, 1);
    chk("t2_n2", 32'(bus.mc_odt), 32'h00C0);
    tick();
    chk("t2_n3", 32'(bus.mc_odt), 32'h00FF);
    tick();
    chk("t2_n4", 32'(bus.mc_odt), 32'h003F);
    ticks(3);

    // Simultaneous rd+wr: only the write window, err[0]
    do_reset();
    c = '0; c.wr_del = 6'd9; c.wr_dur = 6'd6; c.wr_map = 4'b0001;
    c.rd_del = 6'd0; c.rd_dur = 6'd4; c.rd_map = 4'b0101;
    load_cfg(c);
    cas_pulse(1'b1, 1'b1, 0, 0);
    chk("t3_n1", 32'(bus.mc_odt), 32'h0000);
    tick();
    chk("t3_n2", 32'(bus.mc_odt), 32'h007E);
    chk("t3_err", 32'(bus.err), 32'h1);
    ticks(3);

    // Span clip: del 30 dur 6 -> phases 30..31 only, err[1]
    do_reset();
    c = '0; c.wr_del = 6'd30; c.wr_dur = 6'd6; c.wr_map = 4'b0001;
    load_cfg(c);
    cas_pulse(1'b1, 1'b0, 0, 0);
    ticks(3);
    chk("t4_n4", 32'(bus.mc_odt), 32'h00C0);
    tick();
    chk("t4_n5", 32'(bus.mc_odt), 32'h0000);
    chk("t4_err", 32'(bus.err), 32'h2);
    ticks(2);

    // Disable pulse flushes a pending window; scheduling resumes afterwards
    c.wr_del = 6'd9; c.wr_dur = 6'd6;
    load_cfg(c);
    cas_pulse(1'b1, 1'b0, 0, 0);
    bus.odt_disable = 1'b1;
    tick();
    bus.odt_disable = 1'b0;
    chk("t5_mc_odt", 32'(bus.mc_odt), 32'h0000);
    chk("t5_busy", 32'(bus.odt_busy), 32'h0);
    cas_pulse(1'b1, 1'b0, 0, 0);
    tick();
    chk("t5_resume", 32'(bus.mc_odt), 32'h007E);

    // Load while busy is rejected; old config stays in force
    cas_pulse(1'b1, 1'b0, 0, 0);
    c.wr_del = 6'd0; c.wr_dur = 6'd8;
    load_cfg(c);
    chk("t6_err", 32'(bus.err[ERR_CFG]), 32'h1);
    ticks(4);
    cas_pulse(1'b1, 1'b0, 0, 0);
    tick();
    chk("t6_oldcfg", 32'(bus.mc_odt), 32'h007E);
    do_reset();

    // Random traffic against the timeline model
    for (int i = 0; i < 1500; i++) begin
      idle();
      if ($urandom_range(0, 99) < 45) begin
        bus.cas.wr   = 1'($urandom_range(0, 1));
        bus.cas.rd   = ($urandom_range(0, 9) == 0) ? 1'b1 : !bus.cas.wr;
        bus.cas.slot = SW'($urandom_range(0, SLOTS-1));
        bus.cas.rank = RW'($urandom_range(0, RANKS-1));
      end
      if ($urandom_range(0, 99) < 3) bus.odt_disable = 1'b1;
      if ($urandom_range(0, 99) < 6) begin
        c.wr_del = DW'($urandom_range(0, 34));
        c.wr_dur = DW'($urandom_range(0, 10));
        c.rd_del = DW'($urandom_range(0, 34));
        c.rd_dur = DW'($urandom_range(0, 10));
        c.wr_map = 4'($urandom);
        c.rd_map = 4'($urandom);
        bus.cfg = c;
        bus.cfg_load = 1'b1;
      end
      tick();
      if (i == 700) do_reset();
    end
    idle();
    ticks(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
